// File: rtl/pattern_detector_seq.sv
// Debounced push-button sequence detector matching press events against a programmable pattern.
// Optional idle abort is compiled in when PATDET_TIMEOUT_EN is defined.
module pattern_detector_seq #(
  parameter int NUM_BUTTONS    = 2,
  parameter int PAT_LEN        = 4,
  parameter int DEB_CYCLES     = 65535,
  parameter int Z_LATCH        = 0,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int SYM_W         = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1,
  localparam int PROG_W        = $clog2(PAT_LEN + 1)
) (
  input  logic                     sysclock,
  input  logic                     reset_n,
  input  logic [NUM_BUTTONS-1:0]   raw_button,
  input  logic [PAT_LEN*SYM_W-1:0] pattern,
  input  logic                     clear,
  output logic                     z,
  output logic [PROG_W-1:0]        progress,
  output logic [CNT_W-1:0]         match_count,
  output logic                     err,
  output logic                     timeout
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);
  localparam logic [PROG_W-1:0] LAST_PROG = PROG_W'(PAT_LEN - 1);

  typedef enum logic [1:0] {IDLE, MATCHING, HIT} state_t;

  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q, clean_q, clean_d, evt_q;
  logic [DEB_W-1:0]       debCnt_q [NUM_BUTTONS];
  logic [DEB_W-1:0]       debCnt_d [NUM_BUTTONS];

  state_t                 state_q, state_d;
  logic [PROG_W-1:0]      progress_q, progress_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   zLatch_q, zLatch_d;
  logic                   err_q, err_d;
  logic                   hit;

  logic                   anyEvt, multiEvt;
  logic [SYM_W-1:0]       sym, expSym, firstSym;
  logic                   idleExpired;

  // A clean level only follows the synced input after DEB_CYCLES consecutive disagreeing cycles.
  always_comb begin
    clean_d = clean_q;
    for (int b = 0; b < NUM_BUTTONS; b++) begin
      debCnt_d[b] = '0;
      if (sync2_q[b] != clean_q[b]) begin
        if (debCnt_q[b] == DEB_MAX) begin
          clean_d[b] = sync2_q[b];
        end else begin
          debCnt_d[b] = debCnt_q[b] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sysclock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      clean_q <= '0;
      evt_q   <= '0;
      for (int b = 0; b < NUM_BUTTONS; b++) begin
        debCnt_q[b] <= '0;
      end
    end else begin
      sync1_q <= raw_button;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      evt_q   <= clean_d & ~clean_q;
      for (int b = 0; b < NUM_BUTTONS; b++) begin
        debCnt_q[b] <= debCnt_d[b];
      end
    end
  end

  assign anyEvt   = |evt_q;
  assign multiEvt = (evt_q & (evt_q - 1'b1)) != '0;
  assign firstSym = pattern[SYM_W-1:0];

  always_comb begin
    sym    = '0;
    expSym = '0;
    for (int b = 0; b < NUM_BUTTONS; b++) begin
      if (evt_q[b]) sym = SYM_W'(b);
    end
    for (int i = 0; i < PAT_LEN; i++) begin
      if (progress_q == PROG_W'(i)) expSym = pattern[i*SYM_W +: SYM_W];
    end
  end

`ifdef PATDET_TIMEOUT_EN
  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              timeout_q, timeout_d;

  assign idleExpired = (progress_q != '0) && (idle_q == IDLE_MAX);

  // A press or clear in the expiry cycle wins, so the abort pulse is suppressed then.
  always_comb begin
    idle_d    = idle_q + 1'b1;
    timeout_d = idleExpired && !clear && !anyEvt;
    if (clear || anyEvt || (progress_q == '0) || idleExpired) idle_d = '0;
  end

  always_ff @(posedge sysclock or negedge reset_n) begin
    if (!reset_n) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unusedTimeoutCfg;

  assign unusedTimeoutCfg = (TIMEOUT_CYCLES > 0);
  assign idleExpired      = 1'b0;
  assign timeout          = 1'b0;
`endif

  always_comb begin
    progress_d = progress_q;
    count_d    = count_q;
    zLatch_d   = zLatch_q;
    err_d      = 1'b0;
    hit        = 1'b0;
    state_d    = IDLE;
    if (clear) begin
      progress_d = '0;
      count_d    = '0;
      zLatch_d   = 1'b0;
    end else if (anyEvt) begin
      if (multiEvt) begin
        err_d      = 1'b1;
        progress_d = '0;
      end else if (sym == expSym) begin
        if (progress_q == LAST_PROG) begin
          hit        = 1'b1;
          progress_d = '0;
        end else begin
          progress_d = progress_q + 1'b1;
        end
      end else begin
        progress_d = (sym == firstSym) ? PROG_W'(1) : '0;
      end
    end else if (idleExpired) begin
      progress_d = '0;
    end
    if (hit) begin
      zLatch_d = 1'b1;
      if (count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;
    end
    if (hit) begin
      state_d = HIT;
    end else if (progress_d != '0) begin
      state_d = MATCHING;
    end
  end

  always_ff @(posedge sysclock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      progress_q <= '0;
      count_q    <= '0;
      zLatch_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      progress_q <= progress_d;
      count_q    <= count_d;
      zLatch_q   <= zLatch_d;
      err_q      <= err_d;
    end
  end

  // In pulse mode the single HIT cycle is the match indication itself.
  assign z           = (Z_LATCH != 0) ? zLatch_q : (state_q == HIT);
  assign progress    = progress_q;
  assign match_count = count_q;
  assign err         = err_q;

endmodule
